// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types and constants for the SRAM arbiter
package sram_arbiter_pkg;

    localparam int SRAM_ADDR_W = 21;
    localparam int SRAM_DATA_W = 8;
    localparam logic [SRAM_DATA_W-1:0] SRAM_OOR_DATA = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester ports and SRAM pin bundle for the arbiter
interface sram_arbiter_if;
    import sram_arbiter_pkg::*;

    logic                   a_req;
    logic                   a_we;
    logic [SRAM_ADDR_W-1:0] a_addr;
    logic [SRAM_DATA_W-1:0] a_wdata;
    logic                   a_ack;
    logic [SRAM_DATA_W-1:0] a_rdata;
    logic                   b_req;
    logic [SRAM_ADDR_W-1:0] b_addr;
    logic                   b_ack;
    logic [SRAM_DATA_W-1:0] b_rdata;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_dq_out;
    logic                   sram_dq_oe;
    logic [SRAM_DATA_W-1:0] sram_dq_in;
    logic                   sram_we_n;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_addr, sram_dq_in,
        output a_ack, a_rdata, b_ack, b_rdata,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_addr, sram_dq_in,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-port arbiter and fixed-timing engine for async SRAM
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int READ_CYCLES = 2,
    parameter int WE_CYCLES   = 1
) (
    input  logic          clk_chipset,
    input  logic          reset,
    sram_arbiter_if.slave bus
);

    localparam int CNT_MAX = (READ_CYCLES > WE_CYCLES) ? READ_CYCLES : WE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    port_e                  grant_q, grant_d;
    port_e                  last_q, last_d;
    logic                   oor_q, oor_d;
    logic                   wr_q, wr_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   we_n_q, we_n_d;
    logic                   a_ack_q, a_ack_d;
    logic                   b_ack_q, b_ack_d;
    logic [SRAM_DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [SRAM_DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic                   a_pend, b_pend;
    port_e                  pick;
    logic [SRAM_ADDR_W-1:0] sel_addr;
    logic                   sel_we;
    logic [SRAM_DATA_W-1:0] rd_byte;

    // A port still showing its ack this cycle has not yet dropped req, so it is masked.
    assign a_pend   = bus.a_req & ~a_ack_q;
    assign b_pend   = bus.b_req & ~b_ack_q;
    assign pick     = (a_pend && b_pend) ? ((last_q == PORT_A) ? PORT_B : PORT_A)
                                         : (a_pend ? PORT_A : PORT_B);
    assign sel_addr = (pick == PORT_A) ? bus.a_addr : bus.b_addr;
    assign sel_we   = (pick == PORT_A) & bus.a_we;
    assign rd_byte  = oor_q ? SRAM_OOR_DATA : bus.sram_dq_in;

    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            grant_q   <= PORT_A;
            last_q    <= PORT_A;
            oor_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dq_out_q  <= '0;
            dq_oe_q   <= 1'b0;
            we_n_q    <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            oor_q     <= oor_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            dq_out_q  <= dq_out_d;
            dq_oe_q   <= dq_oe_d;
            we_n_q    <= we_n_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        last_d    = last_q;
        oor_d     = oor_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        dq_out_d  = dq_out_q;
        dq_oe_d   = dq_oe_q;
        we_n_d    = we_n_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                dq_oe_d = 1'b0;
                if (a_pend || b_pend) begin
                    grant_d = pick;
                    last_d  = pick;
                    wr_d    = sel_we;
                    cnt_d   = '0;
                    if (sel_addr[SRAM_ADDR_W-1]) begin
                        // Out of range: no SRAM cycle, just a one-edge turnaround through RD_WAIT.
                        oor_d   = 1'b1;
                        state_d = ST_RD_WAIT;
                    end else begin
                        oor_d  = 1'b0;
                        addr_d = sel_addr;
                        if (sel_we) begin
                            dq_out_d = bus.a_wdata;
                            dq_oe_d  = 1'b1;
                            state_d  = ST_WR_SETUP;
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (oor_q || cnt_q == CNT_W'(READ_CYCLES)) begin
                    if (grant_q == PORT_A) begin
                        a_ack_d = 1'b1;
                        if (!wr_q) a_rdata_d = rd_byte;
                    end else begin
                        b_ack_d   = 1'b1;
                        b_rdata_d = rd_byte;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = CNT_W'(1);
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_q == CNT_W'(WE_CYCLES)) begin
                    we_n_d  = 1'b1;
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                a_ack_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.a_ack       = a_ack_q;
    assign bus.b_ack       = b_ack_q;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       use_model = 1'b0;
    logic [7:0] dq_val = 8'h00;
    int         tests = 0;
    int         fails = 0;

    sram_arbiter_if u_if();
    sram_arbiter_if u_if6();

    // SRAM stand-in: either a fixed byte or a pattern derived from the address.
    assign u_if.sram_dq_in  = use_model ? (u_if.sram_addr[7:0] ^ 8'h3C) : dq_val;
    assign u_if6.sram_dq_in = u_if6.sram_addr[7:0] ^ 8'h3C;

    sram_arbiter u_dut (
        .clk_chipset (clk),
        .reset       (rst),
        .bus         (u_if)
    );

    sram_arbiter #(.READ_CYCLES(4), .WE_CYCLES(2)) u_dut6 (
        .clk_chipset (clk),
        .reset       (rst),
        .bus         (u_if6)
    );

    always #10 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got hang, required finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        u_if.a_req = 1'b0;  u_if.a_we = 1'b0;  u_if.a_addr = '0;  u_if.a_wdata = '0;
        u_if.b_req = 1'b0;  u_if.b_addr = '0;
        u_if6.a_req = 1'b0; u_if6.a_we = 1'b0; u_if6.a_addr = '0; u_if6.a_wdata = '0;
        u_if6.b_req = 1'b0; u_if6.b_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({u_if.sram_we_n, u_if.sram_dq_oe, u_if.a_ack, u_if.b_ack} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 1000",
                     {u_if.sram_we_n, u_if.sram_dq_oe, u_if.a_ack, u_if.b_ack});
        end
        tests++;
        if (u_if.sram_addr !== 21'h0) begin
            fails++; $display("FAIL reset_addr: got %h required 000000", u_if.sram_addr);
        end
        tests++;
        if (u_if.sram_dq_out !== 8'h00) begin
            fails++; $display("FAIL reset_dq_out: got %h required 00", u_if.sram_dq_out);
        end
        tests++;
        if ({u_if.a_rdata, u_if.b_rdata} !== 16'h0000) begin
            fails++; $display("FAIL reset_rdata: got %h required 0000", {u_if.a_rdata, u_if.b_rdata});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_a();
        int         ack_n = -1;
        int         acks = 0;
        logic       bad_we = 1'b0;
        logic       bad_oe = 1'b0;
        logic [20:0] addr1 = '0;
        use_model = 1'b0;
        dq_val = 8'h5A;
        u_if.a_we = 1'b0; u_if.a_addr = 21'h012345; u_if.a_req = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n == 1) addr1 = u_if.sram_addr;
            if (!u_if.sram_we_n) bad_we = 1'b1;
            if (u_if.sram_dq_oe) bad_oe = 1'b1;
            if (u_if.a_ack) begin
                acks++;
                if (ack_n < 0) ack_n = n;
                u_if.a_req = 1'b0;
                dq_val = 8'h00;
            end
        end
        tests++;
        if (ack_n != 3) begin fails++; $display("FAIL read_ack_time: got %0d required 3", ack_n); end
        tests++;
        if (acks != 1) begin fails++; $display("FAIL read_ack_count: got %0d required 1", acks); end
        tests++;
        if (u_if.a_rdata !== 8'h5A) begin fails++; $display("FAIL read_rdata: got %h required 5a", u_if.a_rdata); end
        tests++;
        if (addr1 !== 21'h012345) begin fails++; $display("FAIL read_addr: got %h required 012345", addr1); end
        tests++;
        if ({bad_we, bad_oe} !== 2'b00) begin
            fails++; $display("FAIL read_pins_idle: got we_low=%b oe_high=%b required 0 0", bad_we, bad_oe);
        end
    endtask

    task automatic test_write_a();
        int          ack_n = -1;
        int          acks = 0;
        int          oe_cycles = 0;
        logic [11:0] we_low = '0;
        logic        unstable = 1'b0;
        u_if.a_we = 1'b1; u_if.a_addr = 21'h080010; u_if.a_wdata = 8'hC3; u_if.a_req = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (!u_if.sram_we_n) we_low[n] = 1'b1;
            if (u_if.sram_dq_oe) begin
                oe_cycles++;
                if (u_if.sram_addr !== 21'h080010 || u_if.sram_dq_out !== 8'hC3) unstable = 1'b1;
            end
            if (!u_if.sram_we_n && !u_if.sram_dq_oe) unstable = 1'b1;
            if (u_if.a_ack) begin
                acks++;
                if (ack_n < 0) ack_n = n;
                u_if.a_req = 1'b0;
            end
        end
        tests++;
        if (ack_n != 3) begin fails++; $display("FAIL write_ack_time: got %0d required 3", ack_n); end
        tests++;
        if (acks != 1) begin fails++; $display("FAIL write_ack_count: got %0d required 1", acks); end
        tests++;
        if (oe_cycles != 4) begin fails++; $display("FAIL write_oe_cycles: got %0d required 4", oe_cycles); end
        tests++;
        if (we_low !== 12'b0000_0000_0010) begin
            fails++; $display("FAIL write_we_pulse: got %b required 000000000010", we_low);
        end
        tests++;
        if (unstable) begin fails++; $display("FAIL write_stable: got unstable required stable"); end
        tests++;
        if (u_if.a_rdata !== 8'h5A) begin
            fails++; $display("FAIL write_keeps_rdata: got %h required 5a", u_if.a_rdata);
        end
    endtask

    task automatic test_out_of_range();
        int   ack_n = -1;
        logic bad_pins = 1'b0;
        u_if.a_we = 1'b1; u_if.a_addr = 21'h100000; u_if.a_wdata = 8'h77; u_if.a_req = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (!u_if.sram_we_n || u_if.sram_dq_oe) bad_pins = 1'b1;
            if (u_if.a_ack) begin
                if (ack_n < 0) ack_n = n;
                u_if.a_req = 1'b0;
            end
        end
        tests++;
        if (ack_n != 1) begin fails++; $display("FAIL oor_write_ack_time: got %0d required 1", ack_n); end
        tests++;
        if (bad_pins) begin fails++; $display("FAIL oor_write_pins: got sram activity required none"); end
        tests++;
        if (u_if.sram_addr !== 21'h080010) begin
            fails++; $display("FAIL oor_addr_held: got %h required 080010", u_if.sram_addr);
        end
        tests++;
        if (u_if.a_rdata !== 8'h5A) begin
            fails++; $display("FAIL oor_write_rdata: got %h required 5a", u_if.a_rdata);
        end
        ack_n = -1;
        u_if.b_addr = 21'h1FFFFF; u_if.b_req = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (u_if.b_ack) begin
                if (ack_n < 0) ack_n = n;
                u_if.b_req = 1'b0;
            end
        end
        tests++;
        if (ack_n != 1) begin fails++; $display("FAIL oor_read_ack_time: got %0d required 1", ack_n); end
        tests++;
        if (u_if.b_rdata !== 8'hFF) begin fails++; $display("FAIL oor_read_rdata: got %h required ff", u_if.b_rdata); end
    endtask

    task automatic test_reset_mid_write();
        int ack_n = -1;
        int acks = 0;
        use_model = 1'b1;
        u_if.a_we = 1'b1; u_if.a_addr = 21'h000040; u_if.a_wdata = 8'h11; u_if.a_req = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                tests++;
                if (u_if.sram_we_n !== 1'b0) begin
                    fails++; $display("FAIL rst_mid_in_pulse: got we_n=%b required 0", u_if.sram_we_n);
                end
                rst = 1'b1;
                u_if.a_req = 1'b0;
            end
            if (n == 2) begin
                tests++;
                if ({u_if.sram_we_n, u_if.sram_dq_oe} !== 2'b10) begin
                    fails++; $display("FAIL rst_mid_pins: got %b required 10", {u_if.sram_we_n, u_if.sram_dq_oe});
                end
                rst = 1'b0;
            end
            if (u_if.a_ack) acks++;
        end
        tests++;
        if (acks != 0) begin fails++; $display("FAIL rst_mid_no_ack: got %0d required 0", acks); end
        u_if.b_addr = 21'h000055; u_if.b_req = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (u_if.b_ack) begin
                if (ack_n < 0) ack_n = n;
                u_if.b_req = 1'b0;
            end
        end
        tests++;
        if (ack_n != 3) begin fails++; $display("FAIL rst_mid_read_time: got %0d required 3", ack_n); end
        tests++;
        if (u_if.b_rdata !== 8'h69) begin fails++; $display("FAIL rst_mid_read_data: got %h required 69", u_if.b_rdata); end
    endtask

    task automatic test_round_robin();
        port_e order [4];
        port_e exp_order [4];
        int    g = 0;
        int    ai = 0;
        int    bi = 0;
        int    bad_rd = 0;
        logic  both = 1'b0;
        exp_order[0] = PORT_B; exp_order[1] = PORT_A; exp_order[2] = PORT_B; exp_order[3] = PORT_A;
        for (int i = 0; i < 4; i++) order[i] = PORT_A;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        use_model = 1'b1;
        u_if.a_addr = 21'h000200; u_if.b_addr = 21'h000100;
        u_if.a_req = 1'b1; u_if.b_req = 1'b1;
        for (int n = 0; n < 60 && g < 4; n++) begin
            @(negedge clk);
            if (u_if.a_ack && u_if.b_ack) both = 1'b1;
            if (u_if.b_ack && g < 4) begin
                order[g] = PORT_B;
                if (u_if.b_rdata !== (u_if.b_addr[7:0] ^ 8'h3C)) bad_rd++;
                g++; bi++;
                u_if.b_addr = 21'h000100 + 21'(bi);
            end
            if (u_if.a_ack && g < 4) begin
                order[g] = PORT_A;
                if (u_if.a_rdata !== (u_if.a_addr[7:0] ^ 8'h3C)) bad_rd++;
                g++; ai++;
                u_if.a_addr = 21'h000200 + 21'(ai);
            end
        end
        u_if.a_req = 1'b0; u_if.b_req = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (g != 4) begin fails++; $display("FAIL rr_grant_count: got %0d required 4", g); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (order[i] !== exp_order[i]) begin
                fails++; $display("FAIL rr_order[%0d]: got %s required %s", i, order[i].name(), exp_order[i].name());
            end
        end
        tests++;
        if (bad_rd != 0) begin fails++; $display("FAIL rr_rdata: got %0d bad reads required 0", bad_rd); end
        tests++;
        if (both) begin fails++; $display("FAIL rr_dual_ack: got simultaneous acks required none"); end
    endtask

    task automatic test_params();
        int          ack_n = -1;
        logic [11:0] we_low = '0;
        u_if6.a_we = 1'b0; u_if6.a_addr = 21'h000011; u_if6.a_req = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (u_if6.a_ack) begin
                if (ack_n < 0) ack_n = n;
                u_if6.a_req = 1'b0;
            end
        end
        tests++;
        if (ack_n != 5) begin fails++; $display("FAIL p_read_ack_time: got %0d required 5", ack_n); end
        tests++;
        if (u_if6.a_rdata !== 8'h2D) begin fails++; $display("FAIL p_read_rdata: got %h required 2d", u_if6.a_rdata); end
        ack_n = -1;
        u_if6.a_we = 1'b1; u_if6.a_addr = 21'h000022; u_if6.a_wdata = 8'h99; u_if6.a_req = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (!u_if6.sram_we_n) we_low[n] = 1'b1;
            if (u_if6.a_ack) begin
                if (ack_n < 0) ack_n = n;
                u_if6.a_req = 1'b0;
            end
        end
        tests++;
        if (ack_n != 4) begin fails++; $display("FAIL p_write_ack_time: got %0d required 4", ack_n); end
        tests++;
        if (we_low !== 12'b0000_0000_0110) begin
            fails++; $display("FAIL p_write_we_pulse: got %b required 000000000110", we_low);
        end
    endtask

    initial begin
        test_reset();
        test_read_a();
        test_write_a();
        test_out_of_range();
        test_reset_mid_write();
        test_round_robin();
        test_params();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
